// File: rtl/demux18.sv
// Sequential 1-to-8 bit demultiplexer: bits arrive one per handshake at a selected
// position and are assembled into a byte that is published on a valid/ready port.
module demux18 #(
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic [2:0] sel,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] written,
    output logic [7:0] byte_count
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t     state, state_n;
    logic [7:0] shadow, shadow_n;
    logic [7:0] written_n;
    logic [7:0] out_n;
    logic       out_valid_n;
    logic [7:0] byte_count_n;
    logic [7:0] merged_shadow;
    logic [7:0] merged_written;
    logic       accept;

    assign in_ready = (state == COLLECT);
    assign accept   = in_valid & in_ready;

    always_comb begin
        merged_shadow      = shadow;
        merged_shadow[sel] = in;
        merged_written     = written | (8'd1 << sel);
    end

    always_comb begin
        state_n      = state;
        shadow_n     = shadow;
        written_n    = written;
        out_n        = out;
        out_valid_n  = out_valid;
        byte_count_n = byte_count;
        case (state)
            COLLECT: begin
                // flush wins over a simultaneous accept, even a completing one
                if (flush) begin
                    shadow_n  = INIT_VALUE;
                    written_n = 8'h00;
                end else if (accept) begin
                    if (merged_written == 8'hFF) begin
                        out_n        = merged_shadow;
                        out_valid_n  = 1'b1;
                        byte_count_n = byte_count + 8'd1;
                        shadow_n     = INIT_VALUE;
                        written_n    = 8'h00;
                        state_n      = HOLD;
                    end else begin
                        shadow_n  = merged_shadow;
                        written_n = merged_written;
                    end
                end
            end
            HOLD: begin
                // out keeps the last byte after the handshake; only valid drops
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            shadow     <= INIT_VALUE;
            written    <= 8'h00;
            out        <= INIT_VALUE;
            out_valid  <= 1'b0;
            byte_count <= 8'h00;
        end else begin
            state      <= state_n;
            shadow     <= shadow_n;
            written    <= written_n;
            out        <= out_n;
            out_valid  <= out_valid_n;
            byte_count <= byte_count_n;
        end
    end

endmodule

// File: tb/tb_demux18.sv
// Bench for demux18: fixed vector table, hand-written corner sequences and
// random traffic checked against a position-array model of the assembler.
module tb_demux18;

    localparam logic [7:0] INIT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] written;
    logic [7:0] byte_count;

    demux18 #(.INIT_VALUE(INIT)) dut (
        .clk(clk), .rst(rst), .in(in), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .written(written), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int nchk  = 0;

    // reference model: one entry per bit position
    bit       m_bit[8];
    bit       m_wr[8];
    bit       m_pend;
    bit [7:0] m_out;
    int       m_cnt;

    typedef struct {
        logic       i;
        logic [2:0] s;
        logic       v;
        logic       f;
        logic       r;
        logic [7:0] e_out;
        logic       e_ov;
        logic       e_ir;
        logic [7:0] e_wr;
        logic [7:0] e_bc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic m_clear();
        for (int k = 0; k < 8; k++) begin
            m_bit[k] = INIT[k];
            m_wr[k]  = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_clear();
        m_pend = 1'b0;
        m_out  = INIT;
        m_cnt  = 0;
    endtask

    function automatic logic [7:0] m_mask();
        logic [7:0] m = 8'h00;
        for (int k = 0; k < 8; k++) m[k] = m_wr[k];
        return m;
    endfunction

    task automatic m_step(input logic i, input logic [2:0] s, input logic v,
                          input logic f, input logic r);
        int n;
        if (!m_pend) begin
            if (f) m_clear();
            else if (v) begin
                m_bit[s] = i;
                m_wr[s]  = 1'b1;
                n = 0;
                for (int k = 0; k < 8; k++) n += m_wr[k];
                if (n == 8) begin
                    for (int k = 0; k < 8; k++) m_out[k] = m_bit[k];
                    m_pend = 1'b1;
                    m_cnt  = (m_cnt + 1) % 256;
                    m_clear();
                end
            end
        end else if (r) m_pend = 1'b0;
    endtask

    task automatic m_check();
        chk("m_out", out, m_out);
        chk("m_out_valid", {7'd0, out_valid}, {7'd0, m_pend});
        chk("m_in_ready", {7'd0, in_ready}, {7'd0, !m_pend});
        chk("m_written", written, m_mask());
        chk("m_byte_count", byte_count, m_cnt[7:0]);
    endtask

    // called at a falling edge; drives, clocks, then checks at the next falling edge
    task automatic cyc(input logic i, input logic [2:0] s, input logic v,
                       input logic f, input logic r);
        in = i; sel = s; in_valid = v; flush = f; out_ready = r;
        @(posedge clk);
        m_step(i, s, v, f, r);
        @(negedge clk);
        m_check();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    logic [7:0] pat;
    int         seq[9];
    logic       sbit[9];

    initial begin
        // in-order assembly of 8'h3C
        pat = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            tbl[k] = '{i: pat[k], s: 3'(k), v: 1'b1, f: 1'b0, r: 1'b1,
                       e_out: INIT, e_ov: 1'b0, e_ir: 1'b1,
                       e_wr: 8'((16'd1 << (k + 1)) - 16'd1), e_bc: 8'd0};
        end
        tbl[7].e_out = 8'h3C; tbl[7].e_ov = 1'b1; tbl[7].e_ir = 1'b0;
        tbl[7].e_wr  = 8'h00; tbl[7].e_bc = 8'd1;
        tbl[8] = '{i: 1'b0, s: 3'd0, v: 1'b0, f: 1'b0, r: 1'b1,
                   e_out: 8'h3C, e_ov: 1'b0, e_ir: 1'b1, e_wr: 8'h00, e_bc: 8'd1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();

        // asynchronous reset mid-cycle after some partial activity
        cyc(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 3'd5, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out", out, 8'hA5);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_written", written, 8'h00);
        chk("rst_byte_count", byte_count, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        m_reset();

        for (int k = 0; k < 9; k++) begin
            cyc(tbl[k].i, tbl[k].s, tbl[k].v, tbl[k].f, tbl[k].r);
            chk($sformatf("tbl%0d_out", k), out, tbl[k].e_out);
            chk($sformatf("tbl%0d_ov", k), {7'd0, out_valid}, {7'd0, tbl[k].e_ov});
            chk($sformatf("tbl%0d_ir", k), {7'd0, in_ready}, {7'd0, tbl[k].e_ir});
            chk($sformatf("tbl%0d_wr", k), written, tbl[k].e_wr);
            chk($sformatf("tbl%0d_bc", k), byte_count, tbl[k].e_bc);
        end

        // out-of-order with an overwrite of position 3 (1 then 0)
        seq  = '{7, 0, 3, 3, 1, 2, 4, 5, 6};
        sbit = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            cyc(sbit[k], 3'(seq[k]), 1'b1, 1'b0, 1'b0);
            if (k == 7) begin
                chk("ooo_no_early", {7'd0, out_valid}, 8'd0);
                chk("ooo_written8", written, 8'hBF);
            end
        end
        chk("ooo_out", out, 8'h81);
        chk("ooo_ov", {7'd0, out_valid}, 8'd1);
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // backpressure with in_valid and flush held during HOLD
        pat = 8'hF0;
        for (int k = 0; k < 8; k++) cyc(pat[k], 3'(k), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 3'(k), 1'b1, 1'b1, 1'b0);
            chk("bp_out", out, 8'hF0);
            chk("bp_ov", {7'd0, out_valid}, 8'd1);
            chk("bp_ir", {7'd0, in_ready}, 8'd0);
            chk("bp_written", written, 8'h00);
        end
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("bp_release_ov", {7'd0, out_valid}, 8'd0);
        chk("bp_release_out", out, 8'hF0);

        // flush colliding with what would be the completing accept
        for (int k = 0; k < 7; k++) cyc(1'b1, 3'(k), 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 3'd7, 1'b1, 1'b1, 1'b1);
        chk("flush_written", written, 8'h00);
        chk("flush_ov", {7'd0, out_valid}, 8'd0);
        pat = 8'h55;
        for (int k = 0; k < 8; k++) cyc(pat[k], 3'(k), 1'b1, 1'b0, 1'b1);
        chk("flush_out", out, 8'h55);
        chk("flush_ov2", {7'd0, out_valid}, 8'd1);
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            cyc(1'($urandom), 3'($urandom), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 19) == 0), 1'($urandom));
        end

        // reset while possibly holding a pending byte; no spurious valid afterwards
        do_reset();
        m_check();
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // counter wrap over 256 back-to-back bytes, 9 cycles each
        do_reset();
        for (int b = 1; b <= 256; b++) begin
            pat = 8'($urandom);
            for (int k = 0; k < 8; k++) cyc(pat[k], 3'(k), 1'b1, 1'b0, 1'b1);
            if (b == 255) chk("wrap_ff", byte_count, 8'hFF);
            if (b == 256) begin
                chk("wrap_00", byte_count, 8'h00);
                chk("wrap_out", out, pat);
                chk("wrap_ov", {7'd0, out_valid}, 8'd1);
            end
            cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
            if (b == 256) chk("wrap_ir_back", {7'd0, in_ready}, 8'd1);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
